mem: RTL and testbench

//  Word-organised data memory with byte-lane addressing for the core's load/store stage.

---
 rtl/mem_if.sv | 12 +
 rtl/mem.sv | 61 ++++++
 tb/tb_mem.sv | 96 +++++++++
 3 files changed

// File: rtl/mem_if.sv
// mem_if: load/store bus between the core's memory stage and the data memory.
interface mem_if #(parameter int WORD_WIDTH = 32, parameter int ADRS_WIDTH = 32);
  logic [ADRS_WIDTH-1:0]   adrs;
  logic                    rden;
  logic                    wren;
  logic [WORD_WIDTH/8-1:0] byt_en;
  logic                    sign_ext;
  logic [WORD_WIDTH-1:0]   wr_data;
  logic [WORD_WIDTH-1:0]   rd_data;
  modport master (output adrs, rden, wren, byt_en, sign_ext, wr_data, input rd_data);
  modport slave  (input adrs, rden, wren, byt_en, sign_ext, wr_data, output rd_data);
endinterface

// File: rtl/mem.sv
// mem: byte-lane addressed word memory for load/store; define MEM_RD_REG_EN for a registered read port.
module mem #(
  parameter int WORD_WIDTH      = 32,
  parameter int ADRS_WIDTH      = 32,
  parameter int MEM_DEPTH_WORDS = 256
) (
  input logic   clk,
  input logic   rst_n,
  mem_if.slave  bus
);
  localparam int NB = WORD_WIDTH / 8;
  localparam int OW = $clog2(NB);
  localparam int IW = $clog2(MEM_DEPTH_WORDS);
  logic [WORD_WIDTH-1:0] r_mem [MEM_DEPTH_WORDS];
  logic [IW-1:0]         w_idx;
  logic [OW-1:0]         w_off;
  logic [OW+2:0]         w_shamt;
  logic [WORD_WIDTH-1:0] w_word;
  logic [WORD_WIDTH-1:0] w_sh_data;
  logic [NB-1:0]         w_sh_be;
  logic [WORD_WIDTH-1:0] w_raw;
  logic [WORD_WIDTH-1:0] w_ld;
  logic [WORD_WIDTH-1:0] w_rd;
  logic                  w_msb;
  int                    w_hi;
  logic                  w_unused;
  assign w_idx     = bus.adrs[OW +: IW];
  assign w_off     = bus.adrs[OW-1:0];
  assign w_shamt   = {w_off, 3'b000};
  assign w_word    = r_mem[w_idx];
  assign w_sh_data = bus.wr_data << w_shamt;
  assign w_sh_be   = bus.byt_en << w_off;
  assign w_raw     = w_word >> w_shamt;
  assign w_unused  = ^bus.adrs[ADRS_WIDTH-1:OW+IW];
  // Lanes shifted past the word top fall off both shifts, so no spill into the next word.
  always_ff @(posedge clk)
    if (rst_n && bus.wren)
      for (int b = 0; b < NB; b++)
        if (w_sh_be[b]) r_mem[w_idx][8*b +: 8] <= w_sh_data[8*b +: 8];
  // Lanes above the highest enabled one take the sign of that lane's MSB.
  always_comb begin
    w_hi  = 0;
    w_msb = 1'b0;
    for (int b = 0; b < NB; b++)
      if (bus.byt_en[b]) begin
        w_hi  = b;
        w_msb = w_raw[8*b+7];
      end
    for (int b = 0; b < NB; b++)
      w_ld[8*b +: 8] = bus.byt_en[b] ? w_raw[8*b +: 8] :
                       (b > w_hi && bus.sign_ext && w_msb) ? 8'hff : 8'h00;
  end
  assign w_rd = (rst_n && bus.rden && |bus.byt_en) ? w_ld : '0;
`ifdef MEM_RD_REG_EN
  logic [WORD_WIDTH-1:0] r_rd_data;
  always_ff @(posedge clk) r_rd_data <= w_rd;
  assign bus.rd_data = r_rd_data;
`else
  assign bus.rd_data = w_rd;
`endif
endmodule

// File: tb/tb_mem.sv
// tb_mem: directed load/store vectors with hand-computed results for mem.
module tb_mem;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   tests = 0;
  int   fails = 0;
  mem_if #(.WORD_WIDTH(32), .ADRS_WIDTH(32)) bus ();
  mem #(.WORD_WIDTH(32), .ADRS_WIDTH(32), .MEM_DEPTH_WORDS(256)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] exp);
    tests++;
    assert (bus.rd_data === exp) else begin
      fails++;
      $display("FAIL %s: rd_data=%h expected %h", tag, bus.rd_data, exp);
      $error("check %s", tag);
    end
  endtask
  task automatic wr(input logic [31:0] a, input logic [3:0] be, input logic [31:0] d);
    bus.adrs = a; bus.byt_en = be; bus.wr_data = d; bus.wren = 1'b1; bus.rden = 1'b0;
    @(posedge clk); #1;
    bus.wren = 1'b0;
  endtask
  task automatic rd(input string tag, input logic [31:0] a, input logic [3:0] be,
                    input logic se, input logic [31:0] exp);
    bus.adrs = a; bus.byt_en = be; bus.sign_ext = se; bus.rden = 1'b1; bus.wren = 1'b0;
`ifdef MEM_RD_REG_EN
    @(posedge clk);
`endif
    #1;
    chk(tag, exp);
  endtask
  initial begin
    bus.adrs = 32'h20; bus.byt_en = 4'hf; bus.sign_ext = 1'b0;
    bus.wr_data = '0; bus.wren = 1'b0; bus.rden = 1'b1;
    repeat (2) @(posedge clk);
    #1 chk("reset_rd", 32'h0);
    rst_n = 1'b1;
    wr(32'h20, 4'hf, 32'hFEEDF00D);
    rd("word_rw", 32'h20, 4'hf, 1'b0, 32'hFEEDF00D);
    wr(32'h20, 4'h1, 32'h000000AA);
    wr(32'h21, 4'h1, 32'h000000BB);
    wr(32'h22, 4'h1, 32'h000000CC);
    wr(32'h23, 4'h1, 32'h000000DD);
    rd("bytes_word", 32'h20, 4'hf, 1'b0, 32'hDDCCBBAA);
    rd("byte0", 32'h20, 4'h1, 1'b0, 32'h000000AA);
    rd("byte1", 32'h21, 4'h1, 1'b0, 32'h000000BB);
    rd("byte2", 32'h22, 4'h1, 1'b0, 32'h000000CC);
    rd("byte3", 32'h23, 4'h1, 1'b0, 32'h000000DD);
    rd("byte0_sx", 32'h20, 4'h1, 1'b1, 32'hFFFFFFAA);
    wr(32'h20, 4'hf, 32'hFEEDF00D);
    wr(32'h22, 4'h3, 32'h00001234);
    rd("half_st_word", 32'h20, 4'hf, 1'b0, 32'h1234F00D);
    rd("half_ld_zx", 32'h22, 4'h3, 1'b0, 32'h00001234);
    rd("half_ld_sx", 32'h20, 4'h3, 1'b1, 32'hFFFFF00D);
    rd("word_sx_noop", 32'h20, 4'hf, 1'b1, 32'h1234F00D);
    wr(32'h20, 4'hf, 32'h80FF7F01);
    rd("b21_sx_pos", 32'h21, 4'h1, 1'b1, 32'h0000007F);
    rd("b23_sx_neg", 32'h23, 4'h1, 1'b1, 32'hFFFFFF80);
    rd("b23_zx", 32'h23, 4'h1, 1'b0, 32'h00000080);
    rd("half_top_zx", 32'h23, 4'h3, 1'b0, 32'h00000080);
    rd("half_top_sx", 32'h23, 4'h3, 1'b1, 32'h00000080);
    wr(32'h24, 4'hf, 32'h11223344);
    wr(32'h23, 4'h3, 32'h0000BEEF);
    rd("half_spill", 32'h20, 4'hf, 1'b0, 32'hEFFF7F01);
    rd("next_word", 32'h24, 4'hf, 1'b0, 32'h11223344);
    rd("alias_420", 32'h420, 4'hf, 1'b0, 32'hEFFF7F01);
    wr(32'hFFFFFC20, 4'hf, 32'hCAFEBABE);
    rd("alias_hi_wr", 32'h20, 4'hf, 1'b0, 32'hCAFEBABE);
    rd("be0_rd", 32'h20, 4'h0, 1'b1, 32'h0);
    wr(32'h20, 4'h0, 32'hFFFFFFFF);
    rd("be0_wr", 32'h20, 4'hf, 1'b0, 32'hCAFEBABE);
    bus.rden = 1'b0;
    @(posedge clk); #1 chk("rden0", 32'h0);
    bus.adrs = 32'h20; bus.byt_en = 4'hf; bus.wr_data = 32'h55555555;
    bus.rden = 1'b1; bus.wren = 1'b1;
`ifdef MEM_RD_REG_EN
    @(posedge clk); #1 chk("rdw_old", 32'hCAFEBABE);
    bus.wren = 1'b0;
`else
    #1 chk("rdw_old", 32'hCAFEBABE);
    @(posedge clk); #1 bus.wren = 1'b0;
`endif
    rd("rdw_new", 32'h20, 4'hf, 1'b0, 32'h55555555);
    rst_n = 1'b0;
    bus.adrs = 32'h20; bus.byt_en = 4'hf; bus.wr_data = 32'h0;
    bus.wren = 1'b1; bus.rden = 1'b1;
    @(posedge clk); #1 chk("rst_rd0", 32'h0);
    @(posedge clk); #1 chk("rst_rd1", 32'h0);
    rst_n = 1'b1;
    rd("rst_no_wr", 32'h20, 4'hf, 1'b0, 32'h55555555);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
